// File: rtl/pipelined_block_comparator.sv
// rtl/pipelined_block_comparator.sv - streaming multi-block magnitude comparator with valid/ready handshake
// Optional macro COMPARATOR_SIGNED_EN: compare the most significant block as two's complement.
module pipelined_block_comparator #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter bit MSB_FIRST     = 1'b1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     clear_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [REGISTER_SIZE-1:0] block_numA_in,
  input  logic [REGISTER_SIZE-1:0] block_numB_in,
  output logic [1:0]               result_out,
  output logic                     result_valid_out,
  input  logic                     result_ready_in,
  output logic                     busy_out
);

  localparam int CW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BLOCKS - 1);

  // Encodings double as the result_out verdict codes.
  typedef enum logic [1:0] {
    V_EQ = 2'b11,
    V_LT = 2'b01,
    V_GT = 2'b10
  } verdict_e;

  logic [CW-1:0] cnt_q, cnt_d;
  verdict_e      verdict_q, verdict_d;
  logic [1:0]    result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          busy_q, busy_d;

  logic     accept, consume, last_beat;
  logic     a_lt, a_gt;
  verdict_e beat_v, merged_v;

  assign ready_out        = !result_valid_q || result_ready_in;
  assign accept           = valid_in && ready_out && !clear_in;
  assign consume          = result_valid_q && result_ready_in;
  assign last_beat        = (cnt_q == LAST_IDX);
  assign result_out       = result_q;
  assign result_valid_out = result_valid_q;
  assign busy_out         = busy_q;

`ifdef COMPARATOR_SIGNED_EN
  localparam logic [CW-1:0] MSB_IDX = MSB_FIRST ? '0 : LAST_IDX;
  logic msb_beat;
  assign msb_beat = (cnt_q == MSB_IDX);

  always_comb begin
    if (msb_beat) begin
      a_lt = $signed(block_numA_in) < $signed(block_numB_in);
      a_gt = $signed(block_numA_in) > $signed(block_numB_in);
    end else begin
      a_lt = block_numA_in < block_numB_in;
      a_gt = block_numA_in > block_numB_in;
    end
  end
`else
  assign a_lt = block_numA_in < block_numB_in;
  assign a_gt = block_numA_in > block_numB_in;
`endif

  // MSB-first: first difference wins. LSB-first: latest difference wins.
  always_comb begin
    beat_v = V_EQ;
    if (a_lt)      beat_v = V_LT;
    else if (a_gt) beat_v = V_GT;
    if (MSB_FIRST) merged_v = (verdict_q == V_EQ) ? beat_v : verdict_q;
    else           merged_v = (beat_v != V_EQ) ? beat_v : verdict_q;
  end

  always_comb begin
    cnt_d          = cnt_q;
    verdict_d      = verdict_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    busy_d         = busy_q;
    if (clear_in) begin
      cnt_d          = '0;
      verdict_d      = V_EQ;
      result_valid_d = 1'b0;
      busy_d         = 1'b0;
    end else begin
      if (consume) result_valid_d = 1'b0;
      if (accept) begin
        if (last_beat) begin
          cnt_d          = '0;
          verdict_d      = V_EQ;
          result_d       = merged_v;
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          verdict_d = merged_v;
          busy_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q          <= '0;
      verdict_q      <= V_EQ;
      result_q       <= 2'b00;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      verdict_q      <= verdict_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

endmodule

// File: tb/tb_pipelined_block_comparator.sv
// tb/tb_pipelined_block_comparator.sv - directed self-checking bench for pipelined_block_comparator
// Four instances share inputs; each scenario starts with a clear and checks only its instance.
module tb_pipelined_block_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic        result_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic       ready_m, rv_m, busy_m;
  logic [1:0] res_m;
  logic       ready_l, rv_l, busy_l;
  logic [1:0] res_l;
  logic       ready_s, rv_s, busy_s;
  logic [1:0] res_s;
  logic       ready_1, rv_1, busy_1;
  logic [1:0] res_1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_block_comparator #(.REGISTER_SIZE(32), .NUM_BLOCKS(4), .MSB_FIRST(1'b1)) dut_m (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .valid_in(valid), .ready_out(ready_m),
    .block_numA_in(a), .block_numB_in(b), .result_out(res_m), .result_valid_out(rv_m),
    .result_ready_in(result_ready), .busy_out(busy_m));

  pipelined_block_comparator #(.REGISTER_SIZE(32), .NUM_BLOCKS(4), .MSB_FIRST(1'b0)) dut_l (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .valid_in(valid), .ready_out(ready_l),
    .block_numA_in(a), .block_numB_in(b), .result_out(res_l), .result_valid_out(rv_l),
    .result_ready_in(result_ready), .busy_out(busy_l));

  pipelined_block_comparator #(.REGISTER_SIZE(32), .NUM_BLOCKS(2), .MSB_FIRST(1'b1)) dut_s (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .valid_in(valid), .ready_out(ready_s),
    .block_numA_in(a), .block_numB_in(b), .result_out(res_s), .result_valid_out(rv_s),
    .result_ready_in(result_ready), .busy_out(busy_s));

  pipelined_block_comparator #(.REGISTER_SIZE(32), .NUM_BLOCKS(1), .MSB_FIRST(1'b1)) dut_1 (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .valid_in(valid), .ready_out(ready_1),
    .block_numA_in(a), .block_numB_in(b), .result_out(res_1), .result_valid_out(rv_1),
    .result_ready_in(result_ready), .busy_out(busy_1));

  task automatic beat(input logic [31:0] aa, input logic [31:0] bb);
    a = aa; b = bb; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({ready_m, rv_m, res_m, busy_m} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_m got=%b exp=10000", {ready_m, rv_m, res_m, busy_m});
    end
    n_tests++;
    if ({ready_l, rv_l, res_l, busy_l} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_l got=%b exp=10000", {ready_l, rv_l, res_l, busy_l});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_equal();
    do_clear();
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'h1111; b = 32'h1111; valid = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (i < 3) begin
        if ({busy_m, rv_m} !== 2'b10) begin
          n_fail++; $display("FAIL equal_busy beat=%0d got=%b exp=10", i, {busy_m, rv_m});
        end
      end else if ({busy_m, rv_m, res_m} !== 4'b0111) begin
        n_fail++; $display("FAIL equal_result got=%b exp=0111", {busy_m, rv_m, res_m});
      end
    end
    valid = 1'b0;
    idle(1);
    n_tests++;
    if ({rv_m, res_m, ready_m} !== 4'b1110) begin
      n_fail++; $display("FAIL equal_hold got=%b exp=1110", {rv_m, res_m, ready_m});
    end
    result_ready = 1'b1;
    #1;
    n_tests++;
    if (ready_m !== 1'b1) begin
      n_fail++; $display("FAIL equal_ready got=%b exp=1", ready_m);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({rv_m, res_m} !== 3'b011) begin
      n_fail++; $display("FAIL equal_consumed got=%b exp=011", {rv_m, res_m});
    end
    result_ready = 1'b0;
  endtask

  task automatic test_order();
    do_clear();
    result_ready = 1'b0;
    beat(5, 5); beat(3, 9); beat(9, 3); beat(7, 7);
    n_tests++;
    if ({rv_m, res_m} !== 3'b101) begin
      n_fail++; $display("FAIL order_msb got=%b exp=101", {rv_m, res_m});
    end
    n_tests++;
    if ({rv_l, res_l} !== 3'b110) begin
      n_fail++; $display("FAIL order_lsb got=%b exp=110", {rv_l, res_l});
    end
  endtask

  task automatic test_gaps();
    do_clear();
    result_ready = 1'b0;
    beat(1, 2); idle(1); beat(9, 9); idle(2); beat(6, 5); idle(3);
    n_tests++;
    if ({rv_m, busy_m} !== 2'b01) begin
      n_fail++; $display("FAIL gaps_partial got=%b exp=01", {rv_m, busy_m});
    end
    beat(3, 3);
    n_tests++;
    if ({rv_m, res_m, rv_l, res_l} !== 6'b101110) begin
      n_fail++; $display("FAIL gaps_result got=%b exp=101110", {rv_m, res_m, rv_l, res_l});
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(2, 1);
    a = 0; b = 9; valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({rv_m, res_m, ready_m, busy_m} !== 5'b11000) begin
        n_fail++; $display("FAIL bp_hold cycle=%0d got=%b exp=11000", k, {rv_m, res_m, ready_m, busy_m});
      end
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    #1;
    n_tests++;
    if (ready_m !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready got=%b exp=1", ready_m);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({rv_m, busy_m} !== 2'b01) begin
      n_fail++; $display("FAIL bp_accept got=%b exp=01", {rv_m, busy_m});
    end
    for (int i = 0; i < 3; i++) begin
      a = 4; b = 4;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    n_tests++;
    if ({rv_m, res_m, busy_m} !== 4'b1010) begin
      n_fail++; $display("FAIL bp_result got=%b exp=1010", {rv_m, res_m, busy_m});
    end
    result_ready = 1'b0;
  endtask

  task automatic test_clear();
    do_clear();
    result_ready = 1'b0;
    beat(32'hFFFF_FFFF, 0); beat(32'hFFFF_FFFF, 0);
    n_tests++;
    if (busy_m !== 1'b1) begin
      n_fail++; $display("FAIL clear_busy_before got=%b exp=1", busy_m);
    end
    do_clear();
    n_tests++;
    if ({busy_m, rv_m} !== 2'b00) begin
      n_fail++; $display("FAIL clear_after got=%b exp=00", {busy_m, rv_m});
    end
    clear = 1'b1; a = 1; b = 2; valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; valid = 1'b0;
    n_tests++;
    if (busy_m !== 1'b0) begin
      n_fail++; $display("FAIL clear_priority got=%b exp=0", busy_m);
    end
    for (int i = 0; i < 4; i++) begin
      beat(7, 7);
      n_tests++;
      if (i < 3) begin
        if (rv_m !== 1'b0) begin
          n_fail++; $display("FAIL clear_no_result beat=%0d got=%b exp=0", i, rv_m);
        end
      end else if ({rv_m, res_m} !== 3'b111) begin
        n_fail++; $display("FAIL clear_result got=%b exp=111", {rv_m, res_m});
      end
    end
    do_clear();
    n_tests++;
    if (rv_m !== 1'b0) begin
      n_fail++; $display("FAIL clear_pending got=%b exp=0", rv_m);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    result_ready = 1'b0;
    beat(1, 2); beat(1, 2);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy_m, rv_m, res_m, ready_m} !== 5'b00001) begin
      n_fail++; $display("FAIL async_reset got=%b exp=00001", {busy_m, rv_m, res_m, ready_m});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(8, 8);
      n_tests++;
      if (i < 3) begin
        if (rv_m !== 1'b0) begin
          n_fail++; $display("FAIL reset_no_result beat=%0d got=%b exp=0", i, rv_m);
        end
      end else if ({rv_m, res_m} !== 3'b111) begin
        n_fail++; $display("FAIL reset_result got=%b exp=111", {rv_m, res_m});
      end
    end
  endtask

  task automatic test_signed();
    logic [1:0] exp_v;
`ifdef COMPARATOR_SIGNED_EN
    exp_v = 2'b01;
`else
    exp_v = 2'b10;
`endif
    do_clear();
    result_ready = 1'b0;
    beat(32'h8000_0000, 32'h0000_0001); beat(0, 0);
    n_tests++;
    if ({rv_s, res_s} !== {1'b1, exp_v}) begin
      n_fail++; $display("FAIL signed_msb got=%b exp=%b", {rv_s, res_s}, {1'b1, exp_v});
    end
    do_clear();
    beat(5, 5); beat(32'h8000_0000, 32'h0000_0001);
    n_tests++;
    if ({rv_s, res_s} !== 3'b110) begin
      n_fail++; $display("FAIL signed_low_unsigned got=%b exp=110", {rv_s, res_s});
    end
  endtask

  task automatic test_single_block();
    do_clear();
    result_ready = 1'b0;
    beat(3, 4);
    n_tests++;
    if ({rv_1, res_1} !== 3'b101) begin
      n_fail++; $display("FAIL n1_first got=%b exp=101", {rv_1, res_1});
    end
    result_ready = 1'b1; a = 7; b = 2; valid = 1'b1;
    #1;
    n_tests++;
    if (ready_1 !== 1'b1) begin
      n_fail++; $display("FAIL n1_ready got=%b exp=1", ready_1);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({rv_1, res_1} !== 3'b110) begin
      n_fail++; $display("FAIL n1_back_to_back got=%b exp=110", {rv_1, res_1});
    end
    a = 5; b = 5;
    @(posedge clk); #1;
    n_tests++;
    if ({rv_1, res_1} !== 3'b111) begin
      n_fail++; $display("FAIL n1_third got=%b exp=111", {rv_1, res_1});
    end
    valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({rv_1, res_1} !== 3'b011) begin
      n_fail++; $display("FAIL n1_drain got=%b exp=011", {rv_1, res_1});
    end
    result_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_order();
    test_gaps();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_signed();
    test_single_block();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
